// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: cache/hazard inputs and stage-control outputs of the pipeline controller.
interface pipeline_ctrl_if;
    logic        inp_icache_hit;
    logic        inp_dcache_hit;
    logic        inp_mem_ready;
    logic        inp_ex_mem_memRead;
    logic        inp_ex_mem_memWrite;
    logic        inp_ex_mem_branch;
    logic        inp_ex_mem_zero;
    logic        inp_id_ex_memRead;
    logic [2:0]  inp_id_ex_rt;
    logic [2:0]  inp_if_id_rs;
    logic [2:0]  inp_if_id_rt;
    logic        out_pc_en;
    logic        out_if_id_en;
    logic        out_id_ex_en;
    logic        out_ex_mem_en;
    logic        out_mem_wb_en;
    logic        out_if_id_flush;
    logic        out_id_ex_flush;
    logic        out_ex_mem_flush;
    logic        out_pcSrc;
    logic        out_mem_req;
    logic        out_mem_sel;
    logic [1:0]  out_state;
    logic [15:0] out_stall_cnt;

    modport master (
        output inp_icache_hit, inp_dcache_hit, inp_mem_ready,
        output inp_ex_mem_memRead, inp_ex_mem_memWrite, inp_ex_mem_branch, inp_ex_mem_zero,
        output inp_id_ex_memRead, inp_id_ex_rt, inp_if_id_rs, inp_if_id_rt,
        input  out_pc_en, out_if_id_en, out_id_ex_en, out_ex_mem_en, out_mem_wb_en,
        input  out_if_id_flush, out_id_ex_flush, out_ex_mem_flush,
        input  out_pcSrc, out_mem_req, out_mem_sel, out_state, out_stall_cnt
    );

    modport slave (
        input  inp_icache_hit, inp_dcache_hit, inp_mem_ready,
        input  inp_ex_mem_memRead, inp_ex_mem_memWrite, inp_ex_mem_branch, inp_ex_mem_zero,
        input  inp_id_ex_memRead, inp_id_ex_rt, inp_if_id_rs, inp_if_id_rt,
        output out_pc_en, out_if_id_en, out_id_ex_en, out_ex_mem_en, out_mem_wb_en,
        output out_if_id_flush, out_id_ex_flush, out_ex_mem_flush,
        output out_pcSrc, out_mem_req, out_mem_sel, out_state, out_stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: cache-miss stall FSM plus load-use and taken-branch hazard control for a 5-stage pipeline.
module pipeline_ctrl (
    input  logic           inp_clk,
    input  logic           inp_rstn,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, IMISS = 2'd1, DMISS = 2'd2, RESUME = 2'd3} state_t;
    state_t      state;
    logic        sel_q;
    logic [15:0] cnt;
    logic        dmiss, imiss, luh, tb, go, stall;
    assign dmiss = (bus.inp_ex_mem_memRead | bus.inp_ex_mem_memWrite) & ~bus.inp_dcache_hit;
    assign imiss = ~bus.inp_icache_hit;
    assign luh   = bus.inp_id_ex_memRead & (bus.inp_id_ex_rt != 3'd0) &
                   ((bus.inp_id_ex_rt == bus.inp_if_id_rs) | (bus.inp_id_ex_rt == bus.inp_if_id_rt));
    assign tb    = bus.inp_ex_mem_branch & bus.inp_ex_mem_zero;
    // A miss seen in RUN stalls everything in the same cycle, overriding branch and load-use.
    assign go    = inp_rstn & (state == RUN) & ~dmiss & ~imiss;
    assign stall = go & luh & ~tb;
    always_ff @(posedge inp_clk or negedge inp_rstn) begin
        if (!inp_rstn) begin
            state <= RUN;
            sel_q <= 1'b0;
            cnt   <= 16'd0;
        end else begin
            case (state)
                RUN: begin
                    if (dmiss) begin
                        state <= DMISS;
                        sel_q <= 1'b1;
                    end else if (imiss) begin
                        state <= IMISS;
                        sel_q <= 1'b0;
                    end
                end
                IMISS, DMISS: if (bus.inp_mem_ready) state <= RESUME;
                default: state <= RUN;
            endcase
            if (((state != RUN) | luh) && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        end
    end
    assign bus.out_pc_en        = go & ~stall;
    assign bus.out_if_id_en     = go & ~stall;
    assign bus.out_id_ex_en     = go;
    assign bus.out_ex_mem_en    = go;
    assign bus.out_mem_wb_en    = go;
    assign bus.out_if_id_flush  = go & tb;
    assign bus.out_id_ex_flush  = go & (tb | stall);
    assign bus.out_ex_mem_flush = go & tb;
    assign bus.out_pcSrc        = go & tb;
    assign bus.out_mem_req      = inp_rstn & ((state == IMISS) | (state == DMISS));
    // RESUME keeps showing which side was refilled while the line is written.
    assign bus.out_mem_sel      = inp_rstn & ((state == DMISS) ? 1'b1 : (state == IMISS) ? 1'b0 : sel_q);
    assign bus.out_state        = state;
    assign bus.out_stall_cnt    = cnt;
endmodule
